// File: rtl/div_unit_pkg.sv
// Shared encodings for the EX-stage divider handshake and its state machine.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam int unsigned DOUBLE_REG_BUS_W = 64;

endpackage

// File: rtl/div_unit_step.sv
// One restoring-division iteration: trial subtract of the divisor from the upper window.
module div_unit_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   dividend_next_c
);

    logic [WIDTH:0] t;

    assign t = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    // Borrow means the divisor did not fit: shift in a 0 quotient bit.
    always_comb begin
        if (t[WIDTH]) begin
            dividend_next_c = {dividend, 1'b0};
        end else begin
            dividend_next_c = {t[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU; result is {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_e         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2*WIDTH-1:0] dividend, dividend_nxt;
    logic [WIDTH-1:0]   divisor, divisor_nxt;
    logic               sign_mode, sign_mode_nxt;
    logic               sign1, sign1_nxt;
    logic               sign2, sign2_nxt;
    logic [2*WIDTH-1:0] result_nxt;
    logic               ready_nxt;

    logic [2*WIDTH:0]   step_next;
    logic [WIDTH-1:0]   op1_abs, op2_abs;
    logic [WIDTH-1:0]   quo_raw, rem_raw, quo_fix, rem_fix;
    logic               accept, last_iter;

    div_unit_step #(.WIDTH(WIDTH)) u_step (
        .dividend        (dividend),
        .divisor         (divisor),
        .dividend_next_c (step_next)
    );

    assign accept    = (start_i == DIV_START) && !annul_i;
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Magnitudes are taken only for signed operations with a negative operand.
    assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
    assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;

    assign quo_raw = step_next[WIDTH-1:0];
    assign rem_raw = step_next[2*WIDTH:WIDTH+1];
    assign quo_fix = (sign_mode && (sign1 ^ sign2)) ? (~quo_raw + WIDTH'(1)) : quo_raw;
    assign rem_fix = (sign_mode && sign1) ? (~rem_raw + WIDTH'(1)) : rem_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            dividend  <= '0;
            divisor   <= '0;
            sign_mode <= 1'b0;
            sign1     <= 1'b0;
            sign2     <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            dividend  <= dividend_nxt;
            divisor   <= divisor_nxt;
            sign_mode <= sign_mode_nxt;
            sign1     <= sign1_nxt;
            sign2     <= sign2_nxt;
            result_o  <= result_nxt;
            ready_o   <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_FREE: begin
                if (accept) begin
                    state_nxt = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_nxt = DIV_FREE;
                end else if (last_iter) begin
                    state_nxt = DIV_END;
                end
            end
            DIV_BY_ZERO: state_nxt = DIV_END;
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_nxt = DIV_FREE;
                end
            end
            default: state_nxt = DIV_FREE;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_nxt       = cnt;
        dividend_nxt  = dividend;
        divisor_nxt   = divisor;
        sign_mode_nxt = sign_mode;
        sign1_nxt     = sign1;
        sign2_nxt     = sign2;
        result_nxt    = result_o;
        ready_nxt     = ready_o;
        unique case (state)
            DIV_FREE: begin
                if (accept) begin
                    sign_mode_nxt = signed_div_i;
                    sign1_nxt     = opdata1_i[WIDTH-1];
                    sign2_nxt     = opdata2_i[WIDTH-1];
                    cnt_nxt       = '0;
                    dividend_nxt  = {(WIDTH-1)'(0), op1_abs, 1'b0};
                    divisor_nxt   = op2_abs;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    cnt_nxt = '0;
                end else begin
                    dividend_nxt = step_next[2*WIDTH-1:0];
                    cnt_nxt      = cnt + CNT_W'(1);
                    if (last_iter) begin
                        result_nxt = {rem_fix, quo_fix};
                        ready_nxt  = DIV_RESULT_READY;
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_nxt = '0;
                ready_nxt  = DIV_RESULT_READY;
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    result_nxt = '0;
                    ready_nxt  = DIV_RESULT_NOT_READY;
                end
            end
            default: ;
        endcase
    end

endmodule
